sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Cycle-based responder for the asynchronous 16-bit SRAM pin interface: the device end of the bus driven by the SoC's SRAM controller.
- Decodes ce_n/oe_n/we_n/lb_n/ub_n, address and dq. Serves reads with a programmable access latency and commits writes at the end of the write pulse.
- Holds a small internal word array.
- Used as the memory stand-in for controller bring-up and FPGA loopback. Exposes access counters and a write-error flag for checking.

Parameters:
- ADDR_W, 18, width of address_in.
- DATA_W, 16, width of dq; must be 16, split into two 8-bit byte lanes.
- DEPTH, 1024, words in the internal array; index = address_in[log2(DEPTH)-1:0]; upper address bits are ignored (aliasing).
- READ_LATENCY, 10, cycles from accepted read start to dq driven; minimum 1.
- OUTPUT_HOLD, 2, cycles dq stays driven after oe_n or ce_n deasserts.
- WRITE_MIN_PULSE, 4, minimum consecutive cycles with ce_n=0 and we_n=0 for a write to commit.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low.
- ce_n  in  1  chip enable, active-low.
- oe_n  in  1  output enable, active-low.
- we_n  in  1  write enable, active-low; dominates oe_n.
- lb_n  in  1  lower byte lane dq[7:0] enable, active-low.
- ub_n  in  1  upper byte lane dq[15:8] enable, active-low.
- address_in  in  ADDR_W  word address.
- dq  inout  DATA_W  data bus; high-Z when not driving, per-lane.
- drive_active  out  1  high while any dq lane is driven.
- rd_access_cnt  out  16  completed read accesses; wraps at 16'hFFFF.
- wr_commit_cnt  out  16  committed writes; wraps.
- wr_err  out  1  one-cycle pulse when a write pulse ends short of WRITE_MIN_PULSE.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, dq all Z, drive_active=0, counters=0, wr_err=0.
  - Any pending write is discarded with no commit and no wr_err.
  - Array contents are NOT cleared.
- Control pins are sampled at posedge with no synchronizer; all decisions use sampled values.
- States and transitions:
  - IDLE: dq Z.
    - ce_n=0 and we_n=0 -> WRITE_PULSE; wcnt=1; sample dq/lb_n/ub_n.
    - Else ce_n=0 and oe_n=0 -> READ_ACCESS; latch address and lanes; rcnt=1.
  - READ_ACCESS: dq Z; rcnt increments each cycle.
    - Address or lane change -> restart with rcnt=1 and new address.
    - ce_n=1 or oe_n=1 -> IDLE.
    - we_n=0 -> WRITE_PULSE.
    - rcnt==READ_LATENCY -> READ_DRIVE; rd_access_cnt+1.
  - READ_DRIVE: enabled lanes drive mem[idx] lanes; disabled lanes Z.
    - Address change -> READ_ACCESS with rcnt=1; dq goes Z in the same cycle.
    - Lane change -> drive set updates next cycle; no restart.
    - oe_n=1 or ce_n=1 -> READ_HOLD; hcnt=1.
    - we_n=0 -> WRITE_PULSE; dq released immediately.
  - READ_HOLD: keeps driving the last data.
    - hcnt==OUTPUT_HOLD -> IDLE.
    - ce_n=0, oe_n=0, same address -> READ_DRIVE with no new latency and no count.
    - we_n=0 -> WRITE_PULSE; release immediately.
  - WRITE_PULSE: dq never driven. Each cycle capture dq plus lane enables into the write holding register; wcnt increments, saturating at WRITE_MIN_PULSE.
    - The address captured is the address sampled on the last low cycle.
    - we_n=1 or ce_n=1 -> WRITE_COMMIT.
  - WRITE_COMMIT: one cycle.
    - If wcnt>=WRITE_MIN_PULSE: write enabled lanes of the holding register to mem[idx]; disabled lanes unchanged; wr_commit_cnt+1.
    - Else: wr_err=1, no array change.
    - Then IDLE; re-evaluation of pins happens in IDLE the next cycle.
- Simultaneous we_n=0 and oe_n=0: write wins; dq stays Z.
- Both lanes disabled: a read drives nothing, drive_active=0, but it still counts. A write commits nothing but still counts.
- drive_active = OR of per-lane output enables (registered with dq enable).
- Counters wrap modulo 2^16. wr_err is high for exactly one cycle per short pulse.

Test Plan:
- Reset and idle: rst=0 for 3 cycles, all pins high -> dq=16'hzzzz, drive_active=0, both counters 0.
- Write then read:
  - Write 16'hA55A to address 18'h00012, we_n low 6 cycles, both lanes enabled -> wr_commit_cnt=1.
  - Then ce_n=oe_n=0 at that address -> dq=16'hzzzz for 10 cycles, then 16'hA55A.
  - After oe_n rises, dq held 2 cycles, then Z; rd_access_cnt=1.
- Byte lanes:
  - Write 16'hFFFF to address 5, then 16'h1234 with ub_n=1 -> read returns 16'hFF34.
  - Read with lb_n=1 -> dq[7:0]=Z, dq[15:8]=8'hFF.
- Short write: we_n low 2 cycles with data 16'hDEAD on address 5 -> wr_err one-cycle pulse, wr_commit_cnt unchanged, address 5 still reads 16'hFF34.
- Read restart and precedence:
  - Address change from 5 to 6 at cycle 6 of access -> dq Z until 10 cycles after the change.
  - we_n=0 during READ_DRIVE -> dq Z the same cycle.
- Reset mid-write: rst=0 during cycle 3 of a 6-cycle write of 16'h0F0F -> no commit, no wr_err, old contents preserved.

Source files
------------

// File: rtl/sram_responder.sv
// Device end of an asynchronous 16-bit SRAM pin interface: serves reads after a
// programmable latency, commits writes at the end of a long-enough write pulse.

module sram_responder #(
  parameter int unsigned ADDR_W          = 18,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned DEPTH           = 1024,
  parameter int unsigned READ_LATENCY    = 10,
  parameter int unsigned OUTPUT_HOLD     = 2,
  parameter int unsigned WRITE_MIN_PULSE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce_n,
  input  logic              i_oe_n,
  input  logic              i_we_n,
  input  logic              i_lb_n,
  input  logic              i_ub_n,
  input  logic [ADDR_W-1:0] i_address,
  inout  wire  [DATA_W-1:0] io_dq,
  output logic              o_drive_active,
  output logic [15:0]       o_rd_access_cnt,
  output logic [15:0]       o_wr_commit_cnt,
  output logic              o_wr_err
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned RCNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int unsigned HCNT_W = (OUTPUT_HOLD > 0) ? $clog2(OUTPUT_HOLD + 1) : 1;
  localparam int unsigned WCNT_W = (WRITE_MIN_PULSE > 0) ? $clog2(WRITE_MIN_PULSE + 1) : 1;

  localparam logic [RCNT_W-1:0] RdLat   = RCNT_W'(READ_LATENCY);
  localparam logic [HCNT_W-1:0] HoldCyc = HCNT_W'(OUTPUT_HOLD);
  localparam logic [WCNT_W-1:0] WrMin   = WCNT_W'(WRITE_MIN_PULSE);

  typedef enum logic [2:0] {
    StIdle,
    StReadAccess,
    StReadDrive,
    StReadHold,
    StWritePulse,
    StWriteCommit
  } state_e;

  state_e              r_state;
  logic [RCNT_W-1:0]   r_rcnt;
  logic [HCNT_W-1:0]   r_hcnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_lb_n;
  logic                r_rd_ub_n;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_wr_lb_n;
  logic                r_wr_ub_n;
  logic [DATA_W-1:0]   r_dout;
  logic                r_oe_lo;
  logic                r_oe_hi;
  logic [15:0]         r_rd_cnt;
  logic [15:0]         r_wr_cnt;
  logic                r_wr_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic             w_wr_req;
  logic             w_rd_req;
  logic             w_addr_chg;
  logic             w_lane_chg;
  logic             w_wcnt_full;
  logic             w_commit;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_wr_req    = ~i_ce_n & ~i_we_n;
  assign w_rd_req    = ~i_ce_n & ~i_oe_n;
  assign w_addr_chg  = (i_address != r_rd_addr);
  assign w_lane_chg  = (i_lb_n != r_rd_lb_n) | (i_ub_n != r_rd_ub_n);
  assign w_wcnt_full = (r_wcnt >= WrMin);
  assign w_rd_idx    = r_rd_addr[IDX_W-1:0];
  // A reset landing on the commit cycle discards the pending write.
  assign w_commit    = i_rst & (r_state == StWriteCommit) & w_wcnt_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_rcnt    <= '0;
      r_hcnt    <= '0;
      r_wcnt    <= '0;
      r_rd_addr <= '0;
      r_rd_lb_n <= 1'b1;
      r_rd_ub_n <= 1'b1;
      r_wr_idx  <= '0;
      r_wr_data <= '0;
      r_wr_lb_n <= 1'b1;
      r_wr_ub_n <= 1'b1;
      r_dout    <= '0;
      r_oe_lo   <= 1'b0;
      r_oe_hi   <= 1'b0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err <= 1'b0;
      if (w_wr_req && (r_state != StWriteCommit)) begin
        // Write wins over any read activity and releases the bus at once.
        r_state   <= StWritePulse;
        r_oe_lo   <= 1'b0;
        r_oe_hi   <= 1'b0;
        r_wr_idx  <= i_address[IDX_W-1:0];
        r_wr_data <= io_dq;
        r_wr_lb_n <= i_lb_n;
        r_wr_ub_n <= i_ub_n;
        if (r_state != StWritePulse) begin
          r_wcnt <= WCNT_W'(1);
        end else if (!w_wcnt_full) begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_rd_req) begin
              r_state   <= StReadAccess;
              r_rd_addr <= i_address;
              r_rd_lb_n <= i_lb_n;
              r_rd_ub_n <= i_ub_n;
              r_rcnt    <= RCNT_W'(1);
            end
          end
          StReadAccess: begin
            if (!w_rd_req) begin
              r_state <= StIdle;
            end else if (w_addr_chg || w_lane_chg) begin
              r_rd_addr <= i_address;
              r_rd_lb_n <= i_lb_n;
              r_rd_ub_n <= i_ub_n;
              r_rcnt    <= RCNT_W'(1);
            end else if (r_rcnt >= RdLat) begin
              r_state  <= StReadDrive;
              r_dout   <= r_mem[w_rd_idx];
              r_oe_lo  <= ~r_rd_lb_n;
              r_oe_hi  <= ~r_rd_ub_n;
              r_rd_cnt <= r_rd_cnt + 16'd1;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          StReadDrive: begin
            if (!w_rd_req) begin
              r_state <= StReadHold;
              r_hcnt  <= HCNT_W'(1);
            end else if (w_addr_chg) begin
              r_state   <= StReadAccess;
              r_rd_addr <= i_address;
              r_rd_lb_n <= i_lb_n;
              r_rd_ub_n <= i_ub_n;
              r_rcnt    <= RCNT_W'(1);
              r_oe_lo   <= 1'b0;
              r_oe_hi   <= 1'b0;
            end else begin
              // Lane changes only retarget the drive set; the data stays valid.
              r_rd_lb_n <= i_lb_n;
              r_rd_ub_n <= i_ub_n;
              r_oe_lo   <= ~i_lb_n;
              r_oe_hi   <= ~i_ub_n;
            end
          end
          StReadHold: begin
            if (w_rd_req && !w_addr_chg) begin
              r_state   <= StReadDrive;
              r_rd_lb_n <= i_lb_n;
              r_rd_ub_n <= i_ub_n;
              r_oe_lo   <= ~i_lb_n;
              r_oe_hi   <= ~i_ub_n;
            end else if (r_hcnt >= HoldCyc) begin
              r_state <= StIdle;
              r_oe_lo <= 1'b0;
              r_oe_hi <= 1'b0;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
          StWritePulse: begin
            r_state <= StWriteCommit;
          end
          StWriteCommit: begin
            if (w_wcnt_full) begin
              r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
              r_wr_err <= 1'b1;
            end
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
            r_oe_lo <= 1'b0;
            r_oe_hi <= 1'b0;
          end
        endcase
      end
    end
  end

  // Array is intentionally not reset so contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      if (!r_wr_lb_n) begin
        r_mem[r_wr_idx][7:0] <= r_wr_data[7:0];
      end
      if (!r_wr_ub_n) begin
        r_mem[r_wr_idx][DATA_W-1:8] <= r_wr_data[DATA_W-1:8];
      end
    end
  end

  assign io_dq[7:0]        = r_oe_lo ? r_dout[7:0] : 8'hzz;
  assign io_dq[DATA_W-1:8] = r_oe_hi ? r_dout[DATA_W-1:8] : {(DATA_W - 8){1'bz}};

  assign o_drive_active  = r_oe_lo | r_oe_hi;
  assign o_rd_access_cnt = r_rd_cnt;
  assign o_wr_commit_cnt = r_wr_cnt;
  assign o_wr_err        = r_wr_err;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: vector table of bus operations with a read-data
// scoreboard, plus hand-written restart, hold, lane and reset sequences.

module tb_sram_responder;

  localparam int unsigned RL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic        lb_n;
  logic        ub_n;
  logic [17:0] addr;
  logic        tb_en;
  logic [15:0] tb_val;
  tri1  [15:0] dq;
  logic        drive_active;
  logic        wr_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  // Undriven lanes are pulled high, so a released lane reads as 8'hFF.
  assign dq = tb_en ? tb_val : 16'hzzzz;

  sram_responder #(
    .ADDR_W         (18),
    .DATA_W         (16),
    .DEPTH          (1024),
    .READ_LATENCY   (RL),
    .OUTPUT_HOLD    (2),
    .WRITE_MIN_PULSE(4)
  ) u_dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_ce_n         (ce_n),
    .i_oe_n         (oe_n),
    .i_we_n         (we_n),
    .i_lb_n         (lb_n),
    .i_ub_n         (ub_n),
    .i_address      (addr),
    .io_dq          (dq),
    .o_drive_active (drive_active),
    .o_rd_access_cnt(rd_cnt),
    .o_wr_commit_cnt(wr_cnt),
    .o_wr_err       (wr_err)
  );

  int total  = 0;
  int bad    = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    bit          wr;
    logic [17:0] a;
    logic [15:0] d;      // write data, or expected dq for a read
    bit          lb;
    bit          ub;
    bit          oe;
    int          pulse;
    bit          err;
    string       name;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input bit wr, input logic [17:0] a, input logic [15:0] d,
                               input bit lb, input bit ub, input bit oe, input int pulse,
                               input bit err, input string name);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.lb = lb; v.ub = ub; v.oe = oe;
    v.pulse = pulse; v.err = err; v.name = name;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic pins_idle();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; lb_n = 1'b0; ub_n = 1'b0; tb_en = 1'b0;
  endtask

  task automatic wait_drive(output int n, output bit z_ok);
    n = 0;
    z_ok = 1'b1;
    while (!drive_active && n < 30) begin
      tick();
      n++;
      if (!drive_active && dq !== 16'hFFFF) z_ok = 1'b0;
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input bit lb, input bit ub,
                          input bit oe, input int pulse, input bit exp_err, input string name);
    bit       seen_drive;
    bit [2:0] errs;
    seen_drive = 1'b0;
    addr = a; tb_val = d; tb_en = 1'b1; lb_n = lb; ub_n = ub; oe_n = oe; ce_n = 1'b0; we_n = 1'b0;
    repeat (pulse) begin
      tick();
      if (drive_active) seen_drive = 1'b1;
    end
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_en = 1'b0;
    tick(); errs[2] = wr_err;
    tick(); errs[1] = wr_err;
    tick(); errs[0] = wr_err;
    if (!exp_err) exp_wr++;
    chk({name, " drive"}, 32'(seen_drive), 32'd0);
    chk({name, " wr_err"}, 32'(errs), {29'd0, 1'b0, exp_err, 1'b0});
    chk({name, " wr_cnt"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  task automatic do_read(input logic [17:0] a, input bit lb, input bit ub,
                         input logic [15:0] want, input string name);
    int          n;
    bit          z_ok;
    bit          hold_ok;
    logic [15:0] e;
    addr = a; lb_n = lb; ub_n = ub; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    sb_q.push_back(want);
    wait_drive(n, z_ok);
    exp_rd++;
    e = sb_q.pop_front();
    chk({name, " latency"}, 32'(n), 32'(RL + 1));
    chk({name, " z before"}, 32'(z_ok), 32'd1);
    chk({name, " data"}, 32'(dq), 32'(e));
    chk({name, " rd_cnt"}, 32'(rd_cnt), 32'(exp_rd));
    oe_n = 1'b1;
    hold_ok = 1'b1;
    repeat (2) begin
      tick();
      if (!drive_active || dq !== e) hold_ok = 1'b0;
    end
    tick();
    chk({name, " hold"}, 32'(hold_ok), 32'd1);
    chk({name, " release"}, {15'd0, drive_active, dq}, 32'h0000_FFFF);
    ce_n = 1'b1;
  endtask

  initial begin
    int  n;
    bit  z_ok;
    bit  err_seen;
    logic [15:0] e;

    rst_n = 1'b0; addr = '0; tb_val = '0;
    pins_idle();
    repeat (3) tick();
    chk("reset dq", 32'(dq), 32'h0000_FFFF);
    chk("reset drive", 32'(drive_active), 32'd0);
    chk("reset rd_cnt", 32'(rd_cnt), 32'd0);
    chk("reset wr_cnt", 32'(wr_cnt), 32'd0);
    chk("reset wr_err", 32'(wr_err), 32'd0);
    rst_n = 1'b1;
    tick();

    vt.push_back(mkv(1, 18'h00012, 16'hA55A, 0, 0, 1, 6, 0, "wr a55a"));
    vt.push_back(mkv(0, 18'h00012, 16'hA55A, 0, 0, 0, 0, 0, "rd a55a"));
    vt.push_back(mkv(1, 18'h00005, 16'hFFFF, 0, 0, 1, 4, 0, "wr ffff min pulse"));
    vt.push_back(mkv(1, 18'h00005, 16'h1234, 0, 1, 1, 5, 0, "wr 1234 low lane"));
    vt.push_back(mkv(0, 18'h00005, 16'hFF34, 0, 0, 0, 0, 0, "rd ff34"));
    vt.push_back(mkv(0, 18'h00005, 16'hFFFF, 1, 0, 0, 0, 0, "rd upper lane only"));
    vt.push_back(mkv(1, 18'h00005, 16'hDEAD, 0, 0, 1, 2, 1, "wr short 2"));
    vt.push_back(mkv(1, 18'h00005, 16'hBEEF, 0, 0, 1, 3, 1, "wr short 3"));
    vt.push_back(mkv(0, 18'h00005, 16'hFF34, 0, 0, 0, 0, 0, "rd after short"));
    vt.push_back(mkv(1, 18'h00006, 16'h6006, 0, 0, 0, 4, 0, "wr with oe low"));
    vt.push_back(mkv(1, 18'h20406, 16'h7117, 0, 0, 1, 4, 0, "wr alias"));
    vt.push_back(mkv(0, 18'h00006, 16'h7117, 0, 0, 0, 0, 0, "rd alias"));
    vt.push_back(mkv(1, 18'h00006, 16'h0000, 1, 1, 1, 4, 0, "wr no lanes"));
    vt.push_back(mkv(0, 18'h00006, 16'h7117, 0, 0, 0, 0, 0, "rd after no-lane wr"));
    vt.push_back(mkv(0, 18'h00012, 16'hA5FF, 1, 0, 0, 0, 0, "rd a55a upper"));
    vt.push_back(mkv(0, 18'h00012, 16'hFF5A, 0, 1, 0, 0, 0, "rd a55a lower"));

    foreach (vt[i]) begin
      if (vt[i].wr) begin
        do_write(vt[i].a, vt[i].d, vt[i].lb, vt[i].ub, vt[i].oe, vt[i].pulse, vt[i].err,
                 vt[i].name);
      end else begin
        do_read(vt[i].a, vt[i].lb, vt[i].ub, vt[i].d, vt[i].name);
      end
    end

    // Address change on the sixth cycle of an access restarts the latency.
    addr = 18'h5; lb_n = 1'b0; ub_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0;
    z_ok = 1'b1;
    repeat (5) begin
      tick();
      if (drive_active || dq !== 16'hFFFF) z_ok = 1'b0;
    end
    chk("restart z early", 32'(z_ok), 32'd1);
    addr = 18'h6;
    sb_q.push_back(16'h7117);
    wait_drive(n, z_ok);
    exp_rd++;
    e = sb_q.pop_front();
    chk("restart latency", 32'(n), 32'(RL + 1));
    chk("restart z", 32'(z_ok), 32'd1);
    chk("restart data", 32'(dq), 32'(e));
    chk("restart rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    we_n = 1'b0;
    tick();
    chk("we during drive", {15'd0, drive_active, dq}, 32'h0000_FFFF);
    we_n = 1'b1; oe_n = 1'b1; ce_n = 1'b1;
    tick();
    tick();
    chk("we during drive err", 32'(wr_err), 32'd1);
    tick();
    chk("we during drive wr_cnt", 32'(wr_cnt), 32'(exp_wr));

    // Re-asserting oe during hold resumes driving without a new access.
    addr = 18'h12; lb_n = 1'b0; ub_n = 1'b0; ce_n = 1'b0; oe_n = 1'b0;
    sb_q.push_back(16'hA55A);
    wait_drive(n, z_ok);
    exp_rd++;
    e = sb_q.pop_front();
    chk("resume first data", 32'(dq), 32'(e));
    oe_n = 1'b1;
    tick();
    oe_n = 1'b0;
    tick();
    chk("resume data", {15'd0, drive_active, dq}, {15'd0, 1'b1, e});
    chk("resume rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    oe_n = 1'b1;
    repeat (3) tick();
    chk("resume release", 32'(drive_active), 32'd0);
    ce_n = 1'b1;
    tick();

    // Read with both lanes disabled drives nothing but still counts.
    addr = 18'h5; lb_n = 1'b1; ub_n = 1'b1; ce_n = 1'b0; oe_n = 1'b0;
    repeat (RL + 1) tick();
    exp_rd++;
    chk("no-lane rd drive", {15'd0, drive_active, dq}, 32'h0000_FFFF);
    chk("no-lane rd_cnt", 32'(rd_cnt), 32'(exp_rd));
    oe_n = 1'b1;
    repeat (3) tick();
    pins_idle();
    tick();

    // Reset during the third cycle of a six-cycle write discards it quietly.
    addr = 18'h5; tb_val = 16'h0F0F; tb_en = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
    ce_n = 1'b0; we_n = 1'b0;
    err_seen = 1'b0;
    repeat (2) begin
      tick();
      if (wr_err) err_seen = 1'b1;
    end
    rst_n = 1'b0;
    repeat (4) begin
      tick();
      if (wr_err) err_seen = 1'b1;
    end
    pins_idle();
    tick();
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    repeat (3) begin
      tick();
      if (wr_err) err_seen = 1'b1;
    end
    chk("rst mid-write err", 32'(err_seen), 32'd0);
    chk("rst mid-write wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst mid-write rd_cnt", 32'(rd_cnt), 32'd0);
    do_read(18'h5, 0, 0, 16'hFF34, "rd after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
